clk_div_switch: RTL and testbench

Glitch-free programmable clock divider with runtime ratio switching and clean start/stop. It extends the team's glitch-free clock-select family from "pick one of two clocks" to "pick any integer ratio of one source clock." Ratio changes and enable changes take effect only at an output-period boundary, so the output never produces a runt pulse. It sits in clock-generation logic and feeds peripheral or low-power domains from the main clock.

---
 rtl/clk_div_pkg.sv | 8 +
 rtl/clk_div_switch_if.sv | 11 +
 rtl/clk_div_oddext.sv | 14 +
 rtl/clk_div_switch.sv | 59 +++++
 tb/tb_clk_div_switch.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type, minimum ratio and ratio clamp for the clk_div_switch divider.
package clk_div_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int MIN_DIV = 2;
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction
endpackage

// File: rtl/clk_div_switch_if.sv
// clk_div_switch_if: run/ratio control and status bundle for clk_div_switch.
interface clk_div_switch_if #(parameter int CNT_W = 8);
  logic en;
  logic div_req;
  logic [CNT_W-1:0] div_i;
  logic div_busy;
  logic div_ack;
  logic running;
  modport master (output en, div_req, div_i, input div_busy, div_ack, running);
  modport slave (input en, div_req, div_i, output div_busy, div_ack, running);
endinterface

// File: rtl/clk_div_oddext.sv
// clk_div_oddext: stretches odd-ratio high phases by half a source period using a negedge copy.
module clk_div_oddext (
  input  logic clk,
  input  logic rst,
  input  logic clk_i,
  input  logic odd_i,
  output logic clk_o
);
  logic neg_q;
  always_ff @(negedge clk or posedge rst)
    if (rst) neg_q <= 1'b0;
    else neg_q <= clk_i;
  assign clk_o = clk_i | (odd_i & neg_q);
endmodule

// File: rtl/clk_div_switch.sv
// clk_div_switch: glitch-free programmable divider; ratio and enable changes land on period boundaries.
// Define CLK_DIV_ODD_DUTY_EN for 50% duty on odd ratios via clk_div_oddext.
module clk_div_switch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RST_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  clk_div_switch_if.slave ctrl,
  output logic clk_o
);
  localparam logic ST_IDLE = IDLE;
  localparam logic ST_RUN = RUN;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic busy_q, busy_d, ack_q, clk_q, clk_d;
  logic bnd, acc, apply;
  always_comb begin
    bnd = (state_q == ST_IDLE) || (cnt_q == div_q - ONE);
    acc = ctrl.div_req && !busy_q;
    apply = busy_q && bnd;
    pend_d = acc ? CNT_W'(clamp_div(32'(ctrl.div_i))) : pend_q;
    busy_d = acc || (busy_q && !bnd);
    div_d = apply ? pend_q : div_q;
    state_d = bnd ? (ctrl.en ? ST_RUN : ST_IDLE) : state_q;
    cnt_d = (state_d == ST_IDLE || bnd) ? '0 : cnt_q + ONE;
    // high phase first: the first floor(D/2) counts of each period
    clk_d = (state_d == ST_RUN) && (cnt_d < (div_d >> 1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      div_q <= CNT_W'(RST_DIV);
      pend_q <= '0;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      ack_q <= apply;
      clk_q <= clk_d;
    end
  assign ctrl.div_busy = busy_q;
  assign ctrl.div_ack = ack_q;
  assign ctrl.running = (state_q == ST_RUN);
`ifdef CLK_DIV_ODD_DUTY_EN
  clk_div_oddext u_oddext (.clk(clk), .rst(rst), .clk_i(clk_q), .odd_i(div_q[0]), .clk_o(clk_o));
`else
  assign clk_o = clk_q;
`endif
endmodule

// File: tb/tb_clk_div_switch.sv
// tb_clk_div_switch: random run/ratio stimulus scored against a period-queue reference model.
module tb_clk_div_switch;
  localparam int CNT_W = 8;
  localparam int RST_DIV = 2;
  typedef struct {bit clk; bit run; bit busy; bit ack;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_o;
  clk_div_switch_if #(.CNT_W(CNT_W)) ifc();
  clk_div_switch #(.CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (.clk(clk), .rst(rst), .ctrl(ifc), .clk_o(clk_o));
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int m_d = RST_DIV;
  int m_pend = 0;
  bit m_run = 0, m_busy = 0, m_prev = 0;
  bit per[$];
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  // each period is queued as its full list of output levels; a boundary is an empty queue
  always @(posedge clk or posedge rst) begin : model
    exp_t e;
    bit acc, lvl;
    if (rst) begin
      m_d = RST_DIV;
      m_pend = 0;
      m_run = 0;
      m_busy = 0;
      m_prev = 0;
      per.delete();
    end else begin
      acc = ifc.div_req && !m_busy;
      e.ack = 0;
      if (m_run && per.size() > 0) lvl = per.pop_front();
      else begin
        if (m_busy) begin
          m_d = m_pend;
          m_busy = 0;
          e.ack = 1;
        end
        m_run = ifc.en;
        lvl = 0;
        if (m_run) begin
          for (int i = 0; i < m_d; i++) per.push_back(i < m_d / 2);
          lvl = per.pop_front();
        end
      end
      if (acc) begin
        m_pend = (ifc.div_i < 2) ? 2 : int'(ifc.div_i);
        m_busy = 1;
      end
`ifdef CLK_DIV_ODD_DUTY_EN
      e.clk = lvl | (m_d[0] & m_prev);
`else
      e.clk = lvl;
`endif
      m_prev = lvl;
      e.run = m_run;
      e.busy = m_busy;
      sb.push_back(e);
    end
  end
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      chk("clk_o", clk_o, e.clk);
      chk("running", ifc.running, e.run);
      chk("div_busy", ifc.div_busy, e.busy);
      chk("div_ack", ifc.div_ack, e.ack);
    end
  end
  task automatic req(input int d);
    @(negedge clk);
    ifc.div_req = 1'b1;
    ifc.div_i = CNT_W'(d);
    @(negedge clk);
    ifc.div_req = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    ifc.en = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = !ifc.running;
    end
    if (!ok) chk("stop_timeout", ifc.running, 0);
  endtask
  initial begin
    bit ok;
    ifc.en = 1'b0;
    ifc.div_req = 1'b0;
    ifc.div_i = '0;
    #12;
    chk("rst_clk_o", clk_o, 0);
    chk("rst_running", ifc.running, 0);
    chk("rst_busy", ifc.div_busy, 0);
    chk("rst_ack", ifc.div_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    ifc.en = 1'b1;
    repeat (10) @(negedge clk);
    wait_idle();
    req(5);
    repeat (3) @(negedge clk);
    ifc.en = 1'b1;
    repeat (20) @(negedge clk);
    wait_idle();
    req(4);
    ifc.en = 1'b1;
    repeat (5) @(negedge clk);
    req(10);
    req(7);
    repeat (30) @(negedge clk);
    wait_idle();
    req(8);
    ifc.en = 1'b1;
    @(negedge clk);
    ifc.en = 1'b0;
    repeat (12) @(negedge clk);
    req(1);
    req(0);
    ifc.en = 1'b1;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ifc.div_req = ($urandom_range(0, 7) == 0);
      if (ifc.div_req)
        ifc.div_i = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) ifc.en = !ifc.en;
    end
    ifc.div_req = 1'b0;
    wait_idle();
    req(6);
    repeat (3) @(negedge clk);
    ifc.en = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = clk_o;
    end
    if (!ok) chk("rise_timeout", clk_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_clk_o", clk_o, 0);
    chk("midrst_running", ifc.running, 0);
    chk("midrst_busy", ifc.div_busy, 0);
    chk("midrst_ack", ifc.div_ack, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    wait_idle();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
